morse_key_timer: RTL and testbench

- Upstream front-end of the Morse reader; drives the symbol decoder.
- Takes one raw, bouncy Morse key (push-button) and debounces it.
- Times each press and classifies it as dot or dash.
- Times the released gaps and flags letter and word boundaries, so the decoder receives clean, single-cycle symbol events instead of raw switch levels.

---
 rtl/morse_pkg.sv | 16 +
 rtl/key_debounce.sv | 43 ++++
 rtl/morse_key_timer.sv | 162 ++++++++++++++++
 tb/tb_morse_key_timer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared FSM state type and symbol encoding for the Morse key front-end.
package morse_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS,
      GAP,
      WORD_WAIT
   } state_e;

   localparam logic SYM_DOT  = 1'b0;
   localparam logic SYM_DASH = 1'b1;

   localparam int MAX_SYMS_DEF = 5;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus tick-based stability filter for the raw Morse key.
module key_debounce #(
   parameter int DEBOUNCE_TICKS = 10
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic tick_i,
   input  logic key_raw_i,
   output logic key_level_o
);

   localparam int SW = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [SW-1:0] STAB_MAX = SW'(DEBOUNCE_TICKS);

   logic          meta_q;
   logic          sync_q;
   logic          level_q;
   logic [SW-1:0] stab_q;

   // meta_q != sync_q means the synchronised value changes on this edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         level_q <= 1'b0;
         stab_q  <= '0;
      end else begin
         meta_q <= key_raw_i;
         sync_q <= meta_q;
         if (meta_q != sync_q) begin
            stab_q <= '0;
         end else if (tick_i && (stab_q != STAB_MAX)) begin
            stab_q <= stab_q + 1'b1;
            if (stab_q == (STAB_MAX - 1'b1)) begin
               level_q <= sync_q;
            end
         end
      end
   end

   assign key_level_o = level_q;

endmodule

// File: rtl/morse_key_timer.sv
// Morse key front-end: debounce, press/gap timing, dot/dash and letter/word events.
// Define MORSE_TOGGLE_OUT_EN to add sw_out_o toggle outputs for the toggle-driven decoder.
//
// state     | meaning
// IDLE      | no letter in progress, waiting for a press
// PRESS     | key held, timing the press
// GAP       | key released, letter still open
// WORD_WAIT | letter closed, waiting for the word gap
module morse_key_timer
   import morse_pkg::*;
#(
   parameter int TICK_DIV         = 50000,
   parameter int DEBOUNCE_TICKS   = 10,
   parameter int DASH_TICKS       = 200,
   parameter int LETTER_GAP_TICKS = 600,
   parameter int WORD_GAP_TICKS   = 1400,
   parameter int MAX_SYMS         = MAX_SYMS_DEF,
   parameter int CNT_W            = 12
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic       key_raw_i,
   output logic       key_level_o,
   output logic       sym_valid_o,
   output logic       sym_o,
   output logic       letter_end_o,
   output logic       word_end_o,
   output logic [2:0] sym_count_o,
   output logic       overflow_o
`ifdef MORSE_TOGGLE_OUT_EN
   ,
   output logic [1:0] sw_out_o
`endif
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] DASH_C   = CNT_W'(DASH_TICKS);
   localparam logic [CNT_W-1:0] LETTER_C = CNT_W'(LETTER_GAP_TICKS);
   localparam logic [CNT_W-1:0] WORD_C   = CNT_W'(WORD_GAP_TICKS);
   localparam logic [2:0]       MAX_CNT  = 3'(MAX_SYMS);

   logic [PW-1:0]    pre_q;
   logic             tick;
   logic             level;
   state_e           state_q;
   logic [CNT_W-1:0] dur_q;
   logic [CNT_W-1:0] dur_d;
   logic             sym_d;
   logic             sym_valid_q;
   logic             sym_q;
   logic             letter_end_q;
   logic             word_end_q;
   logic [2:0]       cnt_q;
   logic             ovf_q;
`ifdef MORSE_TOGGLE_OUT_EN
   logic [1:0]       sw_q;
`endif

   assign tick = (pre_q == PRE_LAST);

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         pre_q <= '0;
      end else begin
         pre_q <= tick ? '0 : pre_q + 1'b1;
      end
   end

   key_debounce #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
   ) u_debounce (
      .clk_i      (clk_i),
      .rst_ni     (reset_ni),
      .tick_i     (tick),
      .key_raw_i  (key_raw_i),
      .key_level_o(level)
   );

   // One counter serves both press and gap timing; it saturates rather than wraps.
   assign dur_d = (tick && (dur_q != '1)) ? dur_q + 1'b1 : dur_q;
   assign sym_d = (dur_q >= DASH_C) ? SYM_DASH : SYM_DOT;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q      <= IDLE;
         dur_q        <= '0;
         sym_valid_q  <= 1'b0;
         sym_q        <= 1'b0;
         letter_end_q <= 1'b0;
         word_end_q   <= 1'b0;
         cnt_q        <= '0;
         ovf_q        <= 1'b0;
`ifdef MORSE_TOGGLE_OUT_EN
         sw_q         <= 2'b00;
`endif
      end else begin
         sym_valid_q  <= 1'b0;
         letter_end_q <= 1'b0;
         word_end_q   <= 1'b0;
         dur_q        <= dur_d;
         unique case (state_q)
            IDLE: begin
               if (level) begin
                  state_q <= PRESS;
                  dur_q   <= '0;
               end
            end
            PRESS: begin
               if (!level) begin
                  state_q <= GAP;
                  dur_q   <= '0;
                  if (cnt_q < MAX_CNT) begin
                     sym_valid_q <= 1'b1;
                     sym_q       <= sym_d;
                     cnt_q       <= cnt_q + 3'd1;
`ifdef MORSE_TOGGLE_OUT_EN
                     sw_q[sym_d] <= ~sw_q[sym_d];
`endif
                  end else begin
                     ovf_q <= 1'b1;
                  end
               end
            end
            // Threshold is checked before a new press so its pulse is never lost.
            GAP: begin
               if (dur_q == LETTER_C) begin
                  letter_end_q <= 1'b1;
                  cnt_q        <= '0;
                  ovf_q        <= 1'b0;
                  state_q      <= WORD_WAIT;
               end else if (level) begin
                  state_q <= PRESS;
                  dur_q   <= '0;
               end
            end
            WORD_WAIT: begin
               if (dur_q == WORD_C) begin
                  word_end_q <= 1'b1;
                  state_q    <= IDLE;
               end else if (level) begin
                  state_q <= PRESS;
                  dur_q   <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign key_level_o  = level;
   assign sym_valid_o  = sym_valid_q;
   assign sym_o        = sym_q;
   assign letter_end_o = letter_end_q;
   assign word_end_o   = word_end_q;
   assign sym_count_o  = cnt_q;
   assign overflow_o   = ovf_q;
`ifdef MORSE_TOGGLE_OUT_EN
   assign sw_out_o     = sw_q;
`endif

endmodule

// File: tb/tb_morse_key_timer.sv
// Bench for morse_key_timer: event-schedule reference model plus literal checkpoints.
module tb_morse_key_timer;

   localparam int DEB  = 2;
   localparam int DASH = 8;
   localparam int LG   = 12;
   localparam int WG   = 28;
   localparam int MAXS = 5;
   localparam int CW   = 12;
   localparam int SATV = (1 << CW) - 1;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       key_raw = 1'b1;
   logic       key_level;
   logic       sym_valid;
   logic       sym;
   logic       letter_end;
   logic       word_end;
   logic [2:0] sym_count;
   logic       overflow;
`ifdef MORSE_TOGGLE_OUT_EN
   logic [1:0] sw_out;
`endif

   int errors = 0;
   int checks = 0;
   int dut_sv = 0;
   int dut_le = 0;
   int dut_we = 0;
   int last_sym = 0;

   // Reference model: raw sample history and scheduled event times.
   bit       rh [0:DEB];
   bit       m_lvl;
   bit       e_sv;
   bit       e_sym;
   bit       e_le;
   bit       e_we;
   bit       m_ovf;
   bit       sym_v;
   bit [1:0] m_sw;
   int       n;
   int       pe;
   int       sym_t;
   int       let_t;
   int       word_t;
   int       m_cnt;

   always #5 clk = ~clk;

   morse_key_timer #(
      .TICK_DIV        (1),
      .DEBOUNCE_TICKS  (DEB),
      .DASH_TICKS      (DASH),
      .LETTER_GAP_TICKS(LG),
      .WORD_GAP_TICKS  (WG),
      .MAX_SYMS        (MAXS),
      .CNT_W           (CW)
   ) dut (
      .clk_i       (clk),
      .reset_ni    (rst_n),
      .key_raw_i   (key_raw),
      .key_level_o (key_level),
      .sym_valid_o (sym_valid),
      .sym_o       (sym),
      .letter_end_o(letter_end),
      .word_end_o  (word_end),
      .sym_count_o (sym_count),
      .overflow_o  (overflow)
`ifdef MORSE_TOGGLE_OUT_EN
      ,
      .sw_out_o    (sw_out)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit all_eq;
      bit new_lvl;
      int dur;
      n++;
      e_sv = 1'b0;
      e_le = 1'b0;
      e_we = 1'b0;
      if (n == sym_t) begin
         if (m_cnt < MAXS) begin
            e_sv        = 1'b1;
            e_sym       = sym_v;
            m_cnt++;
            m_sw[sym_v] = ~m_sw[sym_v];
         end else begin
            m_ovf = 1'b1;
         end
      end
      if (n == let_t) begin
         e_le  = 1'b1;
         m_cnt = 0;
         m_ovf = 1'b0;
      end
      if (n == word_t) e_we = 1'b1;
      // Level follows the raw key once DEB+1 consecutive samples agree.
      all_eq = 1'b1;
      for (int i = 1; i <= DEB; i++) if (rh[i] != rh[0]) all_eq = 1'b0;
      new_lvl = all_eq ? rh[0] : m_lvl;
      for (int i = DEB; i > 0; i--) rh[i] = rh[i-1];
      rh[0] = key_raw;
      if (new_lvl && !m_lvl) begin
         if (let_t > n + 1) let_t = -1;
         if (word_t > n + 1) word_t = -1;
         pe = (let_t == n + 1 || word_t == n + 1) ? n + 2 : n + 1;
      end else if (!new_lvl && m_lvl) begin
         dur = n - pe;
         if (dur > SATV) dur = SATV;
         sym_t  = n + 1;
         sym_v  = (dur >= DASH);
         let_t  = n + LG + 2;
         word_t = n + WG + 2;
      end
      m_lvl = new_lvl;
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int i = 0; i <= DEB; i++) rh[i] = 1'b0;
            m_lvl = 1'b0; e_sv = 1'b0; e_sym = 1'b0; e_le = 1'b0; e_we = 1'b0;
            m_ovf = 1'b0; m_sw = 2'b00; m_cnt = 0; n = 0; pe = 0;
            sym_t = -1; let_t = -1; word_t = -1;
         end else begin
            model_step();
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("key_level", int'(key_level), int'(m_lvl));
         chk("sym_valid", int'(sym_valid), int'(e_sv));
         if (e_sv) chk("sym", int'(sym), int'(e_sym));
         chk("letter_end", int'(letter_end), int'(e_le));
         chk("word_end", int'(word_end), int'(e_we));
         chk("sym_count", int'(sym_count), m_cnt);
         chk("overflow", int'(overflow), int'(m_ovf));
         chk("pulse_exclusive", int'(sym_valid) + int'(letter_end) + int'(word_end) > 1, 0);
`ifdef MORSE_TOGGLE_OUT_EN
         chk("sw_out", int'(sw_out), int'(m_sw));
`endif
         if (sym_valid) begin
            dut_sv++;
            last_sym = int'(sym);
         end
         if (letter_end) dut_le++;
         if (word_end) dut_we++;
      end
   end

   task automatic hold(input bit v, input int cyc);
      key_raw = v;
      repeat (cyc) @(negedge clk);
      #1;
   endtask

   initial begin
      // Reset with the key already pressed.
      repeat (3) @(negedge clk);
      #1;
      chk("rst_key_level", int'(key_level), 0);
      chk("rst_sym_count", int'(sym_count), 0);
      rst_n = 1'b1;
      hold(1, 3);
      chk("lvl_at_3clk", int'(key_level), 0);
      hold(1, 1);
      chk("lvl_at_4clk", int'(key_level), 1);
      chk("no_pulse_after_rst", dut_sv + dut_le + dut_we, 0);
      hold(1, 10);
      hold(0, 40);
      chk("held_sv", dut_sv, 1);
      chk("held_dash", last_sym, 1);
      chk("held_we", dut_we, 1);

      // Dot then dash, then letter and word gaps.
      hold(1, 4); hold(0, 5); hold(1, 12); hold(0, 6);
      chk("dd_count", int'(sym_count), 2);
      chk("dd_sv", dut_sv, 3);
      chk("dd_last_dash", last_sym, 1);
      hold(0, 30);
      chk("gap_count", int'(sym_count), 0);
      chk("gap_le", dut_le, 2);
      chk("gap_we", dut_we, 2);

      // Short glitches must be filtered.
      for (int i = 0; i < 3; i++) begin
         hold(1, 1); hold(0, 3);
      end
      hold(1, 2); hold(0, 4);
      chk("glitch_level", int'(key_level), 0);
      chk("glitch_sv", dut_sv, 3);

      // Six dots in one letter.
      for (int i = 0; i < 6; i++) begin
         hold(1, 4); hold(0, 5);
      end
      hold(0, 1);
      chk("ovf_set", int'(overflow), 1);
      chk("ovf_count", int'(sym_count), 5);
      chk("ovf_sv", dut_sv, 8);
      hold(0, 14);
      chk("ovf_cleared", int'(overflow), 0);
      chk("ovf_count_cleared", int'(sym_count), 0);
      chk("ovf_le", dut_le, 3);
      hold(0, 20);
      chk("ovf_we", dut_we, 3);

      // Press landing on the letter threshold, then one just before it.
      hold(1, 4); hold(0, 13); hold(1, 4); hold(0, 12); hold(1, 4); hold(0, 40);
      chk("edge_sv", dut_sv, 11);
      chk("edge_le", dut_le, 5);
      chk("edge_we", dut_we, 4);

      // Press longer than counter saturation.
      hold(1, 4200); hold(0, 40);
      chk("sat_sv", dut_sv, 12);
      chk("sat_dash", last_sym, 1);
      chk("sat_we", dut_we, 5);

      // Reset in the middle of a press discards it.
      hold(1, 10);
      rst_n = 1'b0;
      hold(1, 2);
      chk("midrst_level", int'(key_level), 0);
      chk("midrst_valid", int'(sym_valid), 0);
      key_raw = 1'b0;
      rst_n   = 1'b1;
      hold(0, 40);
      chk("midrst_sv", dut_sv, 12);
      chk("midrst_le", dut_le, 6);

      // Dot, dash, dot.
      hold(1, 4); hold(0, 6);
`ifdef MORSE_TOGGLE_OUT_EN
      chk("sw_dot", int'(sw_out), 1);
`endif
      hold(1, 12); hold(0, 6);
`ifdef MORSE_TOGGLE_OUT_EN
      chk("sw_dash", int'(sw_out), 3);
`endif
      hold(1, 4); hold(0, 6);
`ifdef MORSE_TOGGLE_OUT_EN
      chk("sw_dot2", int'(sw_out), 2);
`endif
      chk("ddd_count", int'(sym_count), 3);
      chk("ddd_last_dot", last_sym, 0);
      hold(0, 40);
      chk("final_sv", dut_sv, 15);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
